fast_corner_score: RTL and testbench
====================================

# fast_corner_score

Consumes the per-pixel ring comparison results of the FAST thresholder stage: the 16-bit bright/dark masks and the 16+16 thresholded difference magnitudes. Decides whether the centre pixel is a corner (an arc of at least ARC_LEN circularly contiguous bright or dark ring pixels). Computes its corner score for the downstream non-maximum suppression stage. Fully pipelined: one candidate per enabled cycle, fixed latency of three.

## Interface
- PIXEL_WIDTH, 8: pixel width. Difference inputs are PIXEL_WIDTH+2 bits.
- ARC_LEN, 9: minimum contiguous arc length. Legal range 1..16.
- SCORE_WIDTH, PIXEL_WIDTH+6: score width. Must hold 16 × (2^(PIXEL_WIDTH+2)−1) without overflow.
- clk  in  1  single clock; all flops on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- ce  in  1  clock enable; when low every pipeline register, valid bits included, holds.
- in_vld  in  1  the inputs on this cycle are a valid candidate.
- bright  in  16  bit i set means ring pixel i is brighter than centre + threshold.
- dark  in  16  bit i set means ring pixel i is darker than centre − threshold.
- ob_flat  in  16×(PIXEL_WIDTH+2)  bright magnitudes. Pixel i occupies bits [i*(PIXEL_WIDTH+2) +: PIXEL_WIDTH+2]. Treated as unsigned. Zero where the bright bit is clear.
- od_flat  in  16×(PIXEL_WIDTH+2)  dark magnitudes, same packing as ob_flat.
- out_vld  out  1  corner/score valid.
- corner  out  1  a bright or dark arc of length ≥ ARC_LEN exists.
- score  out  SCORE_WIDTH  corner strength; 0 when corner=0.

## Operation
- Ring index 15 is adjacent to index 0. Arcs wrap around.
- Arc test: arc_b = OR over k=0..15 of (AND of bright[(k+j) mod 16] for j=0..ARC_LEN−1). arc_d is the same test on dark.
- sum_b = unsigned sum of all 16 ob values. sum_d = unsigned sum of all 16 od values. Both are SCORE_WIDTH bits, zero-extended, with no saturation.
- corner = arc_b | arc_d.
- score selection:
  - arc_b=1 and arc_d=0: score = sum_b.
  - arc_b=0 and arc_d=1: score = sum_d.
  - Both arcs set: score = max(sum_b, sum_d); on a tie, sum_b.
  - Neither arc set: score = 0.
- No arc check is made on the magnitude values; the masks alone decide corner.
- Data registers update on every ce=1 cycle regardless of in_vld. out_vld is the only qualifier.
- When out_vld=0, corner and score carry don't-care values. The bench must compare only when out_vld=1.

## Timing
- Stage 1, first enabled edge:
  - Register the 16 per-rotation arc terms for bright and for dark.
  - Register four partial sums of four magnitudes each, for bright and for dark.
  - Register vld1 = in_vld.
- Stage 2: register the OR-reduction giving arc_b and arc_d, the full sums sum_b and sum_d, and vld2.
- Stage 3: register corner, score and out_vld.
- Latency: inputs sampled at edge N appear on the outputs after edge N+2 and are held through edge N+3. That is three enabled edges from sampling to output.
- Throughput: one candidate per enabled cycle. No back-pressure exists; ce is the only stall.
- ce low for M cycles: outputs and all internal state frozen; the latency grows by exactly M.
- Reset values, applied asynchronously on rst_n low and held while low:
  - All pipeline registers cleared.
  - out_vld=0, corner=0, score=0.
- Reset mid-stream: any in-flight candidates are discarded. The first out_vld after rst_n rises belongs to a candidate sampled after the release.

## Structure
- Shared package fast_pkg holds:
  - RING_SIZE=16.
  - The function arc_width(PIXEL_WIDTH) = PIXEL_WIDTH+2.
  - The default ARC_LEN.
  - The ring-index packing convention, also used by the thresholder and the NMS stage.
- Sub-module fast_arc_detect (parameter ARC_LEN; 16-bit mask in; 16 rotation terms out, registered) is instantiated twice, once for bright and once for dark.
- The adder tree and max-select are written inline.

## Test plan
- Wrap-around arc: bright=16'hF01F (bits 0–4 and 12–15, 9 contiguous), every ob=10, dark=0, in_vld=1 → three enabled edges later: out_vld=1, corner=1, score=90.
- Eight-pixel arc: bright=16'h00FF, dark=0 → corner=0, score=0. Then bright=16'h01FF, each set ob=5 → corner=1, score=45.
- Both arcs set: bright=16'h01FF with ob=3, and dark=16'hFF80 with od=4 → corner=1, score=max(27, 36)=36. With both sums equal at 27 → score=27, taken from the bright path.
- Saturating magnitudes: bright=16'hFFFF, every ob=10'h3FF → score=16368 with no truncation at the default SCORE_WIDTH.
- ce stall: stream 5 back-to-back candidates, drop ce for 3 cycles mid-stream → outputs frozen during the stall. Results arrive in order with latency 3+3, with no loss and no duplicates.
- Async reset: assert rst_n=0 between clock edges while out_vld=1 → out_vld, corner and score are 0 immediately. After release, out_vld stays 0 until 3 enabled edges past the first new in_vld.

Source files
------------

// File: rtl/fast_pkg.sv
// Shared FAST pipeline definitions: ring geometry, magnitude width and the ring packing
// convention used by the thresholder, the corner scorer and the NMS stage.
package fast_pkg;

   localparam int RING_SIZE       = 16;
   localparam int DEFAULT_ARC_LEN = 9;

   // Thresholded difference magnitudes carry two guard bits above the pixel width.
   function automatic int arc_width(input int pixel_width);
      return pixel_width + 2;
   endfunction

   // Ring pixel idx of a flattened magnitude bus sits at [ring_lsb(idx, width) +: width].
   function automatic int ring_lsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/fast_arc_detect.sv
// Registered per-rotation arc terms: bit k is set when mask bits k..k+ARC_LEN-1 (mod 16)
// are all set. The caller OR-reduces the terms to decide whether an arc exists.
module fast_arc_detect
   import fast_pkg::*;
#(
   parameter int ARC_LEN = DEFAULT_ARC_LEN
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ce,
   input  logic [RING_SIZE-1:0] mask,
   output logic [RING_SIZE-1:0] rot_terms
);

   logic [2*RING_SIZE-1:0] mask_wrap;
   logic [RING_SIZE-1:0]   rot_next;
   logic [RING_SIZE-1:0]   rot_reg;

   // Doubling the mask turns the circular window into a plain part-select.
   assign mask_wrap = {mask, mask};

   generate
      for (genvar gi = 0; gi < RING_SIZE; gi++) begin : g_rot
         assign rot_next[gi] = &mask_wrap[gi +: ARC_LEN];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rot_reg <= '0;
      end else if (ce) begin
         rot_reg <= rot_next;
      end
   end

   assign rot_terms = rot_reg;

endmodule

// File: rtl/fast_corner_score.sv
// FAST corner decision and score: three-stage pipeline (arc terms + partial sums,
// arc OR + full sums, max-select), one candidate per enabled cycle.
module fast_corner_score
   import fast_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8,
   parameter int ARC_LEN     = DEFAULT_ARC_LEN,
   parameter int SCORE_WIDTH = PIXEL_WIDTH + 6
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic                                         ce,
   input  logic                                         in_vld,
   input  logic [RING_SIZE-1:0]                         bright,
   input  logic [RING_SIZE-1:0]                         dark,
   input  logic [RING_SIZE*arc_width(PIXEL_WIDTH)-1:0]  ob_flat,
   input  logic [RING_SIZE*arc_width(PIXEL_WIDTH)-1:0]  od_flat,
   output logic                                         out_vld,
   output logic                                         corner,
   output logic [SCORE_WIDTH-1:0]                       score
);

   localparam int AW     = arc_width(PIXEL_WIDTH);
   localparam int PSUM_W = AW + 2;
   localparam int NQ     = RING_SIZE / 4;

   // ---------------- stage 1: arc terms, quarter sums ----------------
   logic [RING_SIZE-1:0]       rot_b_reg;
   logic [RING_SIZE-1:0]       rot_d_reg;
   logic [NQ-1:0][PSUM_W-1:0]  psum_b_next;
   logic [NQ-1:0][PSUM_W-1:0]  psum_d_next;
   logic [NQ-1:0][PSUM_W-1:0]  psum_b_reg;
   logic [NQ-1:0][PSUM_W-1:0]  psum_d_reg;
   logic                       vld1_reg;

   fast_arc_detect #(.ARC_LEN(ARC_LEN)) u_arc_bright (
      .clk       (clk),
      .rst_n     (rst_n),
      .ce        (ce),
      .mask      (bright),
      .rot_terms (rot_b_reg)
   );

   fast_arc_detect #(.ARC_LEN(ARC_LEN)) u_arc_dark (
      .clk       (clk),
      .rst_n     (rst_n),
      .ce        (ce),
      .mask      (dark),
      .rot_terms (rot_d_reg)
   );

   generate
      for (genvar gi = 0; gi < NQ; gi++) begin : g_quarter
         assign psum_b_next[gi] = PSUM_W'(ob_flat[ring_lsb(4*gi,   AW) +: AW])
                                + PSUM_W'(ob_flat[ring_lsb(4*gi+1, AW) +: AW])
                                + PSUM_W'(ob_flat[ring_lsb(4*gi+2, AW) +: AW])
                                + PSUM_W'(ob_flat[ring_lsb(4*gi+3, AW) +: AW]);
         assign psum_d_next[gi] = PSUM_W'(od_flat[ring_lsb(4*gi,   AW) +: AW])
                                + PSUM_W'(od_flat[ring_lsb(4*gi+1, AW) +: AW])
                                + PSUM_W'(od_flat[ring_lsb(4*gi+2, AW) +: AW])
                                + PSUM_W'(od_flat[ring_lsb(4*gi+3, AW) +: AW]);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psum_b_reg <= '0;
         psum_d_reg <= '0;
         vld1_reg   <= 1'b0;
      end else if (ce) begin
         psum_b_reg <= psum_b_next;
         psum_d_reg <= psum_d_next;
         vld1_reg   <= in_vld;
      end
   end

   // ---------------- stage 2: arc OR-reduction, full sums ----------------
   logic                   arc_b_next;
   logic                   arc_d_next;
   logic [SCORE_WIDTH-1:0] sum_b_next;
   logic [SCORE_WIDTH-1:0] sum_d_next;
   logic                   arc_b_reg;
   logic                   arc_d_reg;
   logic [SCORE_WIDTH-1:0] sum_b_reg;
   logic [SCORE_WIDTH-1:0] sum_d_reg;
   logic                   vld2_reg;

   assign arc_b_next = |rot_b_reg;
   assign arc_d_next = |rot_d_reg;

   always_comb begin
      sum_b_next = '0;
      sum_d_next = '0;
      for (int q = 0; q < NQ; q++) begin
         sum_b_next = sum_b_next + SCORE_WIDTH'(psum_b_reg[q]);
         sum_d_next = sum_d_next + SCORE_WIDTH'(psum_d_reg[q]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arc_b_reg <= 1'b0;
         arc_d_reg <= 1'b0;
         sum_b_reg <= '0;
         sum_d_reg <= '0;
         vld2_reg  <= 1'b0;
      end else if (ce) begin
         arc_b_reg <= arc_b_next;
         arc_d_reg <= arc_d_next;
         sum_b_reg <= sum_b_next;
         sum_d_reg <= sum_d_next;
         vld2_reg  <= vld1_reg;
      end
   end

   // ---------------- stage 3: corner flag and score select ----------------
   logic                   corner_next;
   logic [SCORE_WIDTH-1:0] score_next;
   logic                   corner_reg;
   logic [SCORE_WIDTH-1:0] score_reg;
   logic                   out_vld_reg;

   // When both arcs exist the larger sum wins; a tie keeps the bright sum.
   always_comb begin
      corner_next = arc_b_reg | arc_d_reg;
      score_next  = '0;
      case ({arc_b_reg, arc_d_reg})
         2'b10:   score_next = sum_b_reg;
         2'b01:   score_next = sum_d_reg;
         2'b11:   score_next = (sum_d_reg > sum_b_reg) ? sum_d_reg : sum_b_reg;
         default: score_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         corner_reg  <= 1'b0;
         score_reg   <= '0;
         out_vld_reg <= 1'b0;
      end else if (ce) begin
         corner_reg  <= corner_next;
         score_reg   <= score_next;
         out_vld_reg <= vld2_reg;
      end
   end

   assign out_vld = out_vld_reg;
   assign corner  = corner_reg;
   assign score   = score_reg;

endmodule

// File: tb/tb_fast_corner_score.sv
// Directed bench for fast_corner_score: arc wrap/length cases, score selection,
// full-scale sums, clock-enable stall and asynchronous reset.
module tb_fast_corner_score;

   localparam int PW   = 8;
   localparam int AW   = PW + 2;
   localparam int SW   = PW + 6;
   localparam int RING = 16;

   logic                 clk;
   logic                 rst_n;
   logic                 ce;
   logic                 in_vld;
   logic [RING-1:0]      bright;
   logic [RING-1:0]      dark;
   logic [RING*AW-1:0]   ob_flat;
   logic [RING*AW-1:0]   od_flat;
   logic                 out_vld;
   logic                 corner;
   logic [SW-1:0]        score;

   int tests_run    = 0;
   int tests_failed = 0;

   fast_corner_score #(
      .PIXEL_WIDTH (PW),
      .ARC_LEN     (9),
      .SCORE_WIDTH (SW)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ce      (ce),
      .in_vld  (in_vld),
      .bright  (bright),
      .dark    (dark),
      .ob_flat (ob_flat),
      .od_flat (od_flat),
      .out_vld (out_vld),
      .corner  (corner),
      .score   (score)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Magnitude v on every ring pixel whose mask bit is set, zero elsewhere.
   function automatic logic [RING*AW-1:0] pack_ring(input logic [RING-1:0] m, input logic [AW-1:0] v);
      logic [RING*AW-1:0] r;
      r = '0;
      for (int i = 0; i < RING; i++)
         if (m[i]) r[i*AW +: AW] = v;
      return r;
   endfunction

   // Entered just after a falling edge; leaves just after the falling edge that follows
   // the third enabled rising edge counted from the sampling edge.
   task automatic run_one(input string tag,
                          input logic [RING-1:0] b, input logic [AW-1:0] vb,
                          input logic [RING-1:0] d, input logic [AW-1:0] vd,
                          input logic exp_c, input int exp_s);
      bright  = b;
      dark    = d;
      ob_flat = pack_ring(b, vb);
      od_flat = pack_ring(d, vd);
      in_vld  = 1'b1;
      ce      = 1'b1;
      @(posedge clk);
      #1;
      in_vld = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check({tag, "_early_vld"}, out_vld, 0);
      @(negedge clk);
      check({tag, "_vld"}, out_vld, 1);
      check({tag, "_corner"}, corner, exp_c);
      check({tag, "_score"}, score, exp_s);
      $display("[TB] %s: vld=%0d corner=%0d score=%0d (want corner=%0d score=%0d)",
               tag, out_vld, corner, score, exp_c, exp_s);
   endtask

   // Five back-to-back candidates with ce held low for three cycles after the third.
   task automatic run_stall();
      int             exp_q[$];
      int             got;
      int             next_cand;
      logic           cur_ce;
      logic           pre_vld;
      logic [SW-1:0]  pre_score;
      got       = 0;
      next_cand = 0;
      for (int c = 0; c < 14; c++) begin
         cur_ce = !(c >= 3 && c <= 5);
         ce     = cur_ce;
         dark    = '0;
         od_flat = '0;
         if (next_cand < 5) begin
            bright  = 16'h01FF;
            ob_flat = pack_ring(16'h01FF, AW'(next_cand + 1));
            in_vld  = 1'b1;
         end else begin
            in_vld  = 1'b0;
         end
         if (cur_ce && in_vld) begin
            exp_q.push_back(9 * (next_cand + 1));
            next_cand++;
         end
         pre_vld   = out_vld;
         pre_score = score;
         @(posedge clk);
         #1;
         if (!cur_ce) begin
            check("stall_vld_hold", out_vld, pre_vld);
            check("stall_score_hold", score, pre_score);
         end else if (out_vld) begin
            check("stall_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               check("stall_score", score, exp_q.pop_front());
               got++;
            end
            $display("[TB] stall cycle %0d: corner=%0d score=%0d", c, corner, score);
         end
         @(negedge clk);
      end
      ce = 1'b1;
      check("stall_count", got, 5);
      check("stall_leftover", exp_q.size(), 0);
   endtask

   initial begin
      rst_n   = 1'b0;
      ce      = 1'b0;
      in_vld  = 1'b0;
      bright  = '0;
      dark    = '0;
      ob_flat = '0;
      od_flat = '0;
      #3;
      check("reset_vld", out_vld, 0);
      check("reset_corner", corner, 0);
      check("reset_score", score, 0);
      $display("[TB] reset: vld=%0d corner=%0d score=%0d", out_vld, corner, score);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ce    = 1'b1;

      run_one("wrap_arc",     16'hF01F, 10'd10,  16'h0000, 10'd0,   1'b1, 90);
      run_one("eight_arc",    16'h00FF, 10'd5,   16'h0000, 10'd0,   1'b0, 0);
      run_one("nine_arc",     16'h01FF, 10'd5,   16'h0000, 10'd0,   1'b1, 45);
      run_one("wrap_eight",   16'hC03F, 10'd7,   16'h0000, 10'd0,   1'b0, 0);
      run_one("alternating",  16'h5555, 10'd9,   16'h0000, 10'd0,   1'b0, 0);
      run_one("dark_only",    16'h0000, 10'd0,   16'hFF80, 10'd7,   1'b1, 63);
      run_one("dark_wrap",    16'h0000, 10'd0,   16'h80FF, 10'd1,   1'b1, 9);
      run_one("both_dark_max",16'h01FF, 10'd3,   16'hFF80, 10'd4,   1'b1, 36);
      run_one("both_tie",     16'h01FF, 10'd3,   16'hFF80, 10'd3,   1'b1, 27);
      run_one("both_brt_max", 16'h01FF, 10'd5,   16'hFF80, 10'd4,   1'b1, 45);
      run_one("full_bright",  16'hFFFF, 10'h3FF, 16'h0000, 10'd0,   1'b1, 16368);
      run_one("full_both",    16'hFFFF, 10'h3FF, 16'hFFFF, 10'h3FF, 1'b1, 16368);
      run_one("dark_no_arc",  16'h0000, 10'd0,   16'h00FF, 10'd50,  1'b0, 0);

      run_stall();

      // Fill the pipeline, then reset between edges while out_vld is high.
      bright  = 16'h01FF;
      ob_flat = pack_ring(16'h01FF, 10'd2);
      dark    = '0;
      od_flat = '0;
      in_vld  = 1'b1;
      ce      = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_pre_vld", out_vld, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_vld", out_vld, 0);
      check("rst_async_corner", corner, 0);
      check("rst_async_score", score, 0);
      $display("[TB] async reset: vld=%0d corner=%0d score=%0d", out_vld, corner, score);
      @(posedge clk);
      #1;
      check("rst_held_vld", out_vld, 0);
      @(negedge clk);
      rst_n  = 1'b1;
      in_vld = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_flush_vld", out_vld, 0);
      end
      run_one("after_rst",    16'hF01F, 10'd10,  16'h0000, 10'd0,   1'b1, 90);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
